dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 (CPU core load/store path) and port 1 (debug/DMA loader).
- Round-robin arbitration with a same-cycle grant, then a registered memory-request stage and a registered read-return stage.
- Sits between the requesters and data_memory and drives its data_addr, write_data, write_enable and output_enable pins.
- Sustains one access per cycle.

Parameters:
- DATA_W, 8, data word width.
- D_ADDR_W, 12, data address width.
- CNT_W, 16, performance counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  D_ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 request accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DATA_W  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_addr  out  D_ADDR_W  to data_memory data_addr.
- mem_wdata  out  DATA_W  to data_memory write_data.
- mem_we  out  1  to data_memory write_enable.
- mem_oe  out  1  to data_memory output_enable.
- mem_rdata  in  DATA_W  from data_memory read_data (combinational read of mem_addr).

Behaviour:
- Reset (asynchronous, active-high) values:
  - mem_addr=0, mem_wdata=0, mem_we=0, mem_oe=0.
  - p*_rvalid=0, p*_rdata=0.
  - Internal stage registers cleared; last_owner=1, so port 0 wins the first conflict.
- Arbitration (combinational, cycle N):
  - Only p0_req → p0_gnt=1.
  - Only p1_req → p1_gnt=1.
  - Both → grant the port != last_owner.
  - At most one gnt high per cycle; gnt is never asserted without the matching req.
  - last_owner updates on every grant.
- Requester rule: hold req, we, addr and wdata stable until gnt is seen. The request is consumed on the gnt cycle; deasserting req before gnt is legal (the request is withdrawn).
- Stage 1 (cycle N+1), registered from the granted request:
  - mem_addr and mem_wdata load the granted addr and wdata.
  - mem_we = granted we.
  - mem_oe = granted !we.
  - owner and is_read are also registered.
- No grant in cycle N: mem_we=0 and mem_oe=0 in N+1; mem_addr and mem_wdata hold their previous values.
- Write: data_memory commits at the N+1→N+2 edge. No rvalid is produced.
- Stage 2 (cycle N+2), reads only: the owner's p_rdata is loaded from mem_rdata and the owner's p_rvalid=1 for exactly one cycle.
  - rvalid on a port is low when no read of that port completes that cycle.
  - p_rdata holds its last value when rvalid=0.
- Read latency is 2 cycles from gnt; throughput is one access per cycle. Back-to-back grants produce back-to-back rvalids in grant order.
- Ordering is strict grant order across both ports. A read granted in cycle N+1 to the address written by the grant in cycle N returns the new data.
- Continuous conflict alternates p0, p1, p0, p1, ... No starvation; worst-case wait is 1 cycle.
- Reset asserted mid-operation: in-flight stage 1 and stage 2 entries are discarded. No rvalid and no mem_we after reset. A write already registered in stage 1 does not commit if reset precedes the edge.

Optional Feature:
- Macro DMEM_PORT_ARB_PERF_CNT_EN.
- Defined: adds outputs p0_grant_cnt, p1_grant_cnt and conflict_cnt, each CNT_W wide and reset to 0.
  - p*_grant_cnt increments on each grant to that port.
  - conflict_cnt increments each cycle both req are high.
  - All counters saturate at all-ones (no wrap).
- Not defined: those ports and registers do not exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset, then p0 write addr 0x010 data 0xA5 → p0_gnt same cycle; next cycle mem_we=1, mem_addr=0x010, mem_wdata=0xA5. Then p0 read 0x010 → p0_rvalid 2 cycles after gnt, p0_rdata=0xA5.
- p0 and p1 both read continuously for 6 cycles → grants alternate p0,p1,p0,p1,p0,p1 starting with p0; each port gets 3 rvalids 2 cycles after its grants.
- p1 writes 0x7FF=0x3C and p0 reads 0x7FF on the next cycle → p0_rdata=0x3C. Address 0xFFF boundary write/read round-trips correctly.
- Idle cycle between requests → mem_we=0, mem_oe=0, mem_addr unchanged; no rvalid on either port.
- Assert reset one cycle after a p1 write grant to 0x020=0x55 → mem_we never pulses; memory at 0x020 unchanged; all outputs return to reset values asynchronously.
- With DMEM_PORT_ARB_PERF_CNT_EN and CNT_W=4: 20 cycles of dual requests → p0_grant_cnt=10, p1_grant_cnt=10, conflict_cnt=0xF (saturated).

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between a CPU port (p0) and a debug/DMA port (p1).
// Define DMEM_PORT_ARB_PERF_CNT_EN to add saturating grant and conflict counters.
module dmem_port_arbiter #(
  parameter int DATA_W   = 8,
  parameter int D_ADDR_W = 12
`ifdef DMEM_PORT_ARB_PERF_CNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [D_ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  output logic                p0_gnt,
  output logic                p0_rvalid,
  output logic [DATA_W-1:0]   p0_rdata,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [D_ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  output logic                p1_gnt,
  output logic                p1_rvalid,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic [D_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic                mem_oe,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef DMEM_PORT_ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    p0_grant_cnt,
  output logic [CNT_W-1:0]    p1_grant_cnt,
  output logic [CNT_W-1:0]    conflict_cnt
`endif
);

  logic                r_last_owner;
  logic                r_s1_owner;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_any_gnt;
  logic                w_g_we;
  logic [D_ADDR_W-1:0] w_g_addr;
  logic [DATA_W-1:0]   w_g_wdata;

  // On conflict the port that did not win last time is granted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (p0_req && p1_req) begin
      w_gnt0 = r_last_owner;
      w_gnt1 = !r_last_owner;
    end else begin
      w_gnt0 = p0_req;
      w_gnt1 = p1_req;
    end
  end

  assign p0_gnt    = w_gnt0;
  assign p1_gnt    = w_gnt1;
  assign w_any_gnt = w_gnt0 | w_gnt1;
  assign w_g_we    = w_gnt1 ? p1_we    : p0_we;
  assign w_g_addr  = w_gnt1 ? p1_addr  : p0_addr;
  assign w_g_wdata = w_gnt1 ? p1_wdata : p0_wdata;

  // Stage 1: registered memory request; mem_oe doubles as the stage-1 is_read flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_owner <= 1'b1;
      r_s1_owner   <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      mem_oe       <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      mem_we <= w_any_gnt & w_g_we;
      mem_oe <= w_any_gnt & !w_g_we;
      if (w_any_gnt) begin
        mem_addr     <= w_g_addr;
        mem_wdata    <= w_g_wdata;
        r_s1_owner   <= w_gnt1;
        r_last_owner <= w_gnt1;
      end
    end
  end

  // Stage 2: capture read data for the owner; rdata holds between returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= mem_oe & !r_s1_owner;
      p1_rvalid <= mem_oe & r_s1_owner;
      if (mem_oe && !r_s1_owner) p0_rdata <= mem_rdata;
      if (mem_oe && r_s1_owner)  p1_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_PORT_ARB_PERF_CNT_EN
  logic w_conflict;
  assign w_conflict = p0_req & p1_req;

  // Counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_grant_cnt <= '0;
      p1_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if (w_gnt0 && (p0_grant_cnt != '1))     p0_grant_cnt <= p0_grant_cnt + CNT_W'(1);
      if (w_gnt1 && (p1_grant_cnt != '1))     p1_grant_cnt <= p1_grant_cnt + CNT_W'(1);
      if (w_conflict && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: random and directed traffic against a grant-order memory model.
module tb_dmem_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_oe;
`ifdef DMEM_PORT_ARB_PERF_CNT_EN
  logic [3:0]    p0_grant_cnt, p1_grant_cnt, conflict_cnt;
`endif

  logic          t_req   [2];
  logic          t_we    [2];
  logic [AW-1:0] t_addr  [2];
  logic [DW-1:0] t_wdata [2];
  logic          seen    [2];

  assign p0_req = t_req[0];  assign p0_we = t_we[0];  assign p0_addr = t_addr[0];  assign p0_wdata = t_wdata[0];
  assign p1_req = t_req[1];  assign p1_we = t_we[1];  assign p1_addr = t_addr[1];  assign p1_wdata = t_wdata[1];

  dmem_port_arbiter #(
    .DATA_W(DW),
    .D_ADDR_W(AW)
`ifdef DMEM_PORT_ARB_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_rdata(mem_rdata)
`ifdef DMEM_PORT_ARB_PERF_CNT_EN
    , .p0_grant_cnt(p0_grant_cnt), .p1_grant_cnt(p1_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical data_memory: combinational read, write on the rising edge.
  logic [DW-1:0] phys_mem [0:4095];
  logic [DW-1:0] ref_mem  [0:4095];
  always @(posedge clk) if (mem_we) phys_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = phys_mem[mem_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int due; } wr_t;
  typedef struct { logic [DW-1:0] data; int due; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q0[$];
  rd_t rd_q1[$];

  // Read value in grant order: newest uncommitted write wins over committed memory.
  function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
    for (int i = wr_q.size() - 1; i >= 0; i--)
      if (wr_q[i].addr == a) return wr_q[i].data;
    return ref_mem[a];
  endfunction

  // Reference model: grant decision, expected memory-side request, expected read returns.
  int            m_last = 1;
  logic          x_we = 1'b0, x_oe = 1'b0;
  logic [AW-1:0] x_addr = '0;
  logic [DW-1:0] x_wdata = '0;
  int            m_c0 = 0, m_c1 = 0, m_cf = 0;

  always @(negedge clk) begin
    int            g;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rd_t           r;
    if (reset) begin
      check("rst_mem_we", 32'(mem_we), 32'(0));
      check("rst_mem_oe", 32'(mem_oe), 32'(0));
      check("rst_mem_addr", 32'(mem_addr), 32'(0));
      check("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'(0));
      check("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'(0));
      wr_q.delete(); rd_q0.delete(); rd_q1.delete();
      m_last = 1; x_we = 1'b0; x_oe = 1'b0; x_addr = '0; x_wdata = '0;
      m_c0 = 0; m_c1 = 0; m_cf = 0;
    end else begin
      while (wr_q.size() > 0 && wr_q[0].due <= cyc) begin
        ref_mem[wr_q[0].addr] = wr_q[0].data;
        void'(wr_q.pop_front());
      end
      check("mem_we", 32'(mem_we), 32'(x_we));
      check("mem_oe", 32'(mem_oe), 32'(x_oe));
      check("mem_addr", 32'(mem_addr), 32'(x_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(x_wdata));
      if (p0_req && p1_req) g = 1 - m_last;
      else if (p0_req)      g = 0;
      else if (p1_req)      g = 1;
      else                  g = -1;
      check("p0_gnt", 32'(p0_gnt), 32'(g == 0));
      check("p1_gnt", 32'(p1_gnt), 32'(g == 1));
`ifdef DMEM_PORT_ARB_PERF_CNT_EN
      check("p0_grant_cnt", 32'(p0_grant_cnt), 32'(m_c0));
      check("p1_grant_cnt", 32'(p1_grant_cnt), 32'(m_c1));
      check("conflict_cnt", 32'(conflict_cnt), 32'(m_cf));
      if (g == 0 && m_c0 < CNT_MAX) m_c0++;
      if (g == 1 && m_c1 < CNT_MAX) m_c1++;
      if (p0_req && p1_req && m_cf < CNT_MAX) m_cf++;
`endif
      x_we = 1'b0;
      x_oe = 1'b0;
      if (g >= 0) begin
        m_last  = g;
        we      = (g == 1) ? p1_we    : p0_we;
        a       = (g == 1) ? p1_addr  : p0_addr;
        d       = (g == 1) ? p1_wdata : p0_wdata;
        x_we    = we;
        x_oe    = !we;
        x_addr  = a;
        x_wdata = d;
        if (we) wr_q.push_back('{a, d, cyc + 2});
        else begin
          r.data = lookup(a);
          r.due  = cyc + 2;
          if (g == 1) rd_q1.push_back(r);
          else        rd_q0.push_back(r);
        end
      end
    end
  end

  // Monitor: pops the expected read whenever a port presents rvalid.
  logic [DW-1:0] last0 = '0, last1 = '0;
  always @(negedge clk) begin
    rd_t e;
    if (reset) begin
      last0 = '0;
      last1 = '0;
    end else begin
      if (p0_rvalid) begin
        if (rd_q0.size() == 0) check("p0_rvalid_spurious", 32'(p0_rvalid), 32'(0));
        else begin
          e = rd_q0.pop_front();
          check("p0_rdata", 32'(p0_rdata), 32'(e.data));
          check("p0_rvalid_cycle", 32'(cyc), 32'(e.due));
          last0 = e.data;
        end
      end else begin
        check("p0_rdata_hold", 32'(p0_rdata), 32'(last0));
        if (rd_q0.size() > 0 && rd_q0[0].due <= cyc) begin
          check("p0_rvalid_missing", 32'(p0_rvalid), 32'(1));
          void'(rd_q0.pop_front());
        end
      end
      if (p1_rvalid) begin
        if (rd_q1.size() == 0) check("p1_rvalid_spurious", 32'(p1_rvalid), 32'(0));
        else begin
          e = rd_q1.pop_front();
          check("p1_rdata", 32'(p1_rdata), 32'(e.data));
          check("p1_rvalid_cycle", 32'(cyc), 32'(e.due));
          last1 = e.data;
        end
      end else begin
        check("p1_rdata_hold", 32'(p1_rdata), 32'(last1));
        if (rd_q1.size() > 0 && rd_q1[0].due <= cyc) begin
          check("p1_rvalid_missing", 32'(p1_rvalid), 32'(1));
          void'(rd_q1.pop_front());
        end
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    seen[0] = p0_gnt;
    seen[1] = p1_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    t_req[p] = req; t_we[p] = we; t_addr[p] = a; t_wdata[p] = d;
  endtask

  task automatic idle(input int n);
    t_req[0] = 1'b0;
    t_req[1] = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_port(p, 1'b1, we, a, d);
    for (int k = 0; k < 8; k++) begin
      step();
      if (seen[p]) break;
    end
    check("issue_granted", 32'(seen[p]), 32'(1));
    t_req[p] = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 12'h010;
      1: return 12'h7FF;
      2: return 12'hFFF;
      3: return 12'h000;
      4: return 12'h001;
      5: return 12'h123;
      6: return 12'h800;
      default: return 12'h3A5;
    endcase
  endfunction

  task automatic rand_port(input int p);
    if (t_req[p] && !seen[p]) begin
      if ($urandom_range(0, 15) == 0) t_req[p] = 1'b0;
    end else begin
      set_port(p, ($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      phys_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    for (int p = 0; p < 2; p++) begin
      set_port(p, 1'b0, 1'b0, '0, '0);
      seen[p] = 1'b0;
    end
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Write then read back through port 0.
    issue(0, 1'b1, 12'h010, 8'hA5);
    issue(0, 1'b0, 12'h010, 8'h00);
    idle(3);

    // A p1 access leaves p1 as last owner, so the dual stream starts with p0.
    issue(1, 1'b0, 12'h7FF, 8'h00);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      set_port(0, 1'b1, 1'b0, 12'h010, 8'h00);
      set_port(1, 1'b1, 1'b0, 12'h7FF, 8'h00);
      step();
    end
    idle(4);

    // Read-after-write across ports, then the top address.
    set_port(1, 1'b1, 1'b1, 12'h7FF, 8'h3C);
    step();
    set_port(1, 1'b0, 1'b0, '0, '0);
    set_port(0, 1'b1, 1'b0, 12'h7FF, 8'h00);
    step();
    idle(3);
    issue(0, 1'b1, 12'hFFF, 8'h81);
    issue(1, 1'b0, 12'hFFF, 8'h00);
    idle(3);

    // Reset while a write sits in stage 1: it must never reach memory.
    set_port(1, 1'b1, 1'b1, 12'h020, 8'h55);
    step();
    check("rst_case_gnt", 32'(seen[1]), 32'(1));
    t_req[1] = 1'b0;
    reset = 1'b1;
    #1;
    check("async_rst_mem_we", 32'(mem_we), 32'(0));
    check("async_rst_mem_addr", 32'(mem_addr), 32'(0));
    check("async_rst_mem_wdata", 32'(mem_wdata), 32'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(3);
    check("mem020_after_reset", 32'(phys_mem[12'h020]), 32'(ref_mem[12'h020]));

    // Random traffic with holds and withdrawals.
    for (int i = 0; i < 1500; i++) begin
      rand_port(0);
      rand_port(1);
      step();
    end
    idle(5);
    check("reads_drained", 32'(rd_q0.size() + rd_q1.size()), 32'(0));
    check("mem_7ff_consistent", 32'(phys_mem[12'h7FF]), 32'(ref_mem[12'h7FF]));
    check("mem_fff_consistent", 32'(phys_mem[12'hFFF]), 32'(ref_mem[12'hFFF]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
